// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// one big-endian byte per cycle, with bounds checking against the memory depth.
module instr_mem_loader #(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] word_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Pointer carries one extra bit so a full memory reads as DEPTH, never 0.
  localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W + 1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W:0]   ptr_r, ptr_s;
  logic [1:0]        idx_r, idx_s;
  logic [31:0]       word_r, word_s;
  logic              last_r, last_s;
  logic [ADDR_W-2:0] count_r, count_s;
  logic [7:0]        byte_s;

  logic              word_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    sel_byte = w[31:24];
      2'd1:    sel_byte = w[23:16];
      2'd2:    sel_byte = w[15:8];
      2'd3:    sel_byte = w[7:0];
      default: sel_byte = 8'h00;
    endcase
  endfunction

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    idx_s   = idx_r;
    word_s  = word_r;
    last_s  = last_r;
    count_s = count_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_s = ST_ACCEPT;
          ptr_s   = BASE_PTR;
          idx_s   = 2'd0;
          count_s = (ADDR_W - 1)'(0);
        end else begin
          state_s = state_r;
        end
      end
      ST_ACCEPT: begin
        if (word_valid) begin
          if (ptr_r <= LAST_PTR) begin
            state_s = ST_WRITE;
            idx_s   = 2'd0;
            word_s  = word_data;
            last_s  = word_last;
          end else begin
            state_s = ST_ERROR;
          end
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_WRITE: begin
        ptr_s = ptr_r + (ADDR_W + 1)'(1);
        idx_s = idx_r + 2'd1;
        if (idx_r == 2'd3) begin
          count_s = count_r + (ADDR_W - 1)'(1);
          state_s = last_r ? ST_DONE : ST_ACCEPT;
        end else begin
          state_s = ST_WRITE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = BASE_PTR;
        idx_s   = 2'd0;
        count_s = (ADDR_W - 1)'(0);
      end
    endcase
    byte_s = sel_byte(word_s, idx_s);
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= (ADDR_W + 1)'(0);
      idx_r        <= 2'd0;
      word_r       <= 32'h0000_0000;
      last_r       <= 1'b0;
      count_r      <= (ADDR_W - 1)'(0);
      word_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= ADDR_W'(0);
      mem_wdata_r  <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      idx_r        <= idx_s;
      word_r       <= word_s;
      last_r       <= last_s;
      count_r      <= count_s;
      word_ready_r <= (state_s == ST_ACCEPT);
      mem_we_r     <= (state_s == ST_WRITE);
      mem_addr_r   <= ptr_s[ADDR_W-1:0];
      mem_wdata_r  <= byte_s;
      busy_r       <= (state_s == ST_ACCEPT) || (state_s == ST_WRITE);
      done_r       <= (state_s == ST_DONE);
      err_r        <= (state_s == ST_ERROR);
    end
  end

  assign word_ready = word_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign word_count = count_r;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 9, byte-address width of the target instruction memory (DEPTH = 2**ADDR_W bytes).
REQ-002 Parameter BASE_ADDR, default 0, first byte address written in each load session; SHALL be a multiple of 4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begins a load session; sampled only in IDLE, DONE, ERROR.
REQ-006 word_valid  input  1  word_data/word_last valid this cycle.
REQ-007 word_data  input  32  instruction word to store.
REQ-008 word_last  input  1  marks final word of the session.
REQ-009 word_ready  output  1  loader accepts a word this cycle.
REQ-010 mem_we  output  1  byte write strobe to instruction memory.
REQ-011 mem_addr  output  ADDR_W  byte address of the write.
REQ-012 mem_wdata  output  8  byte written.
REQ-013 busy  output  1  high in ACCEPT or WRITE.
REQ-014 done  output  1  high while in DONE.
REQ-015 err  output  1  high while in ERROR.
REQ-016 word_count  output  ADDR_W-1  words fully written in current/last session.

Function
REQ-017 FSM states IDLE, ACCEPT, WRITE, DONE, ERROR; SHALL encode no other reachable state.
REQ-018 IDLE/DONE/ERROR with start=1 -> ACCEPT; pointer <= BASE_ADDR, word_count <= 0.
REQ-019 word_ready SHALL be 1 only in ACCEPT and combinationally independent of word_valid.
REQ-020 Transfer occurs on an edge where word_valid & word_ready; word_data and word_last captured in that edge.
REQ-021 On transfer with pointer <= DEPTH-4 -> WRITE with byte index 0; otherwise -> ERROR, no write performed.
REQ-022 In WRITE, each of 4 consecutive cycles: mem_we=1, mem_addr=pointer, mem_wdata=captured byte; pointer increments by 1 per cycle.
REQ-023 Byte order big-endian: byte index 0..3 = word[31:24], [23:16], [15:8], [7:0], so the memory reads back {m[a],m[a+1],m[a+2],m[a+3]} equal to the word.
REQ-024 Latency: transfer at edge N -> mem_we high in cycles N+1..N+4; next word_ready no earlier than cycle N+5 (max 1 word / 5 cycles).
REQ-025 After 4th byte: word_count increments; if captured last=1 -> DONE, else -> ACCEPT.
REQ-026 mem_we SHALL be 0 in every state other than WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL not be X after reset.
REQ-027 start is ignored in ACCEPT and WRITE; word_valid ignored outside ACCEPT.
REQ-028 Session filling exactly to DEPTH-1 is legal; a further word (last or not) SHALL go to ERROR.
REQ-029 Pointer arithmetic is ADDR_W+1 bits wide internally; no silent wrap to address 0.
REQ-030 DONE and ERROR hold until start or rst; word_count holds its final value there.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, word_count=0.
REQ-032 rst asserted mid-WRITE SHALL drop mem_we asynchronously; partially written word is not counted.
REQ-033 After rst deasserts, loader remains in IDLE until start.

Verification
REQ-034 start, then words 0x00430820, 0x00430822 (last) -> bytes 00,43,08,20,00,43,08,22 at addresses 0..7, done=1, word_count=2.
REQ-035 word_valid held high through WRITE -> only one transfer per 5 cycles; word_ready low cycles N+1..N+4.
REQ-036 ADDR_W=4, 5 words without last -> 4 words written at 0..15, 5th accepted -> err=1, no mem_we, word_count=4.
REQ-037 rst pulsed during 2nd byte of a word -> mem_we=0 same cycle, all outputs at reset values, start required to resume.
REQ-038 start asserted while busy -> no effect; start in DONE -> new session from BASE_ADDR, done=0, word_count=0.
